// File: rtl/mul_lopd_norm_seq_if.sv
// rtl/mul_lopd_norm_seq_if.sv - request/result bundle for the mantissa normaliser
// Exponent signals exist only when MUL_LOPD_NORM_EXP_ADJ_EN is defined.
interface mul_lopd_norm_seq_if #(
  parameter int DATA_W = 48,
  parameter int LZC_W  = $clog2(DATA_W + 1)
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
  ,
  parameter int EXP_W  = 8
`endif
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_mant;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_mant;
  logic [LZC_W-1:0]  o_lzc;
  logic              o_zero;
  logic              o_busy;
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
  logic [EXP_W-1:0]  i_exp;
  logic [EXP_W-1:0]  o_exp;
  logic              o_uflow;
`endif

  modport master (
    output i_valid, i_mant, i_ready,
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
    output i_exp,
    input  o_exp, o_uflow,
`endif
    input  o_ready, o_valid, o_mant, o_lzc, o_zero, o_busy
  );

  modport slave (
    input  i_valid, i_mant, i_ready,
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
    input  i_exp,
    output o_exp, o_uflow,
`endif
    output o_ready, o_valid, o_mant, o_lzc, o_zero, o_busy
  );
endinterface

// File: rtl/mul_lopd_norm_seq.sv
// rtl/mul_lopd_norm_seq.sv - multi-cycle leading-zero normaliser, one 16-bit chunk per cycle
// Optional exponent adjust/underflow under MUL_LOPD_NORM_EXP_ADJ_EN.
module mul_lopd_16bit (
  input  logic [15:0] chunk,
  output logic [3:0]  pos,
  output logic        zf
);
  // Later (higher) set bits override, so pos ends as the MSB's leading-zero count.
  always_comb begin
    pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (chunk[i]) pos = 4'(15 - i);
    end
  end

  assign zf = (chunk == 16'd0);
endmodule

module mul_lopd_norm_seq #(
  parameter int DATA_W = 48,
  parameter int LZC_W  = $clog2(DATA_W + 1)
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
  ,
  parameter int EXP_W  = 8
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mul_lopd_norm_seq_if.slave  bus
);
  localparam int NCHUNK = DATA_W / 16;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mant_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LZC_W-1:0]  acc_q;
  logic              valid_q;
  logic [DATA_W-1:0] mant_out_q;
  logic [LZC_W-1:0]  lzc_q;
  logic              zero_q;

  logic [15:0]       chunk_arr [NCHUNK];
  logic [15:0]       chunk;
  logic [3:0]        pos;
  logic              zf;
  logic [LZC_W-1:0]  lz_sum;
  logic              last_chunk;

  for (genvar j = 0; j < NCHUNK; j++) begin : g_chunk
    assign chunk_arr[j] = mant_q[DATA_W-1-16*j -: 16];
  end

  assign chunk      = chunk_arr[idx_q];
  assign lz_sum     = acc_q + LZC_W'(pos);
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  mul_lopd_16bit u_lopd (
    .chunk (chunk),
    .pos   (pos),
    .zf    (zf)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      mant_q     <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      valid_q    <= 1'b0;
      mant_out_q <= '0;
      lzc_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            mant_q <= bus.i_mant;
            idx_q  <= '0;
            acc_q  <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (!zf) begin
            lzc_q      <= lz_sum;
            mant_out_q <= mant_q << lz_sum;
            zero_q     <= 1'b0;
            valid_q    <= 1'b1;
            state      <= DONE;
          end else if (!last_chunk) begin
            acc_q <= acc_q + LZC_W'(16);
            idx_q <= idx_q + 1'b1;
          end else begin
            lzc_q      <= LZC_W'(DATA_W);
            mant_out_q <= '0;
            zero_q     <= 1'b1;
            valid_q    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_busy  = (state != IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_mant  = mant_out_q;
  assign bus.o_lzc   = lzc_q;
  assign bus.o_zero  = zero_q;

`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
  // Compare in a width wide enough for both operands so the subtraction never wraps unseen.
  localparam int CMP_W = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;

  logic [EXP_W-1:0] exp_q;
  logic [EXP_W-1:0] exp_out_q;
  logic             uflow_q;
  logic [CMP_W-1:0] exp_ext;
  logic [CMP_W-1:0] lz_ext;
  logic [CMP_W-1:0] exp_diff;

  assign exp_ext  = CMP_W'(exp_q);
  assign lz_ext   = CMP_W'(lz_sum);
  assign exp_diff = exp_ext - lz_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q     <= '0;
      exp_out_q <= '0;
      uflow_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.i_valid) begin
        exp_q <= bus.i_exp;
      end else if (state == SCAN) begin
        if (!zf) begin
          if (exp_ext >= lz_ext) begin
            exp_out_q <= exp_diff[EXP_W-1:0];
            uflow_q   <= 1'b0;
          end else begin
            exp_out_q <= '0;
            uflow_q   <= 1'b1;
          end
        end else if (last_chunk) begin
          exp_out_q <= '0;
          uflow_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.o_exp   = exp_out_q;
  assign bus.o_uflow = uflow_q;
`endif
endmodule

// File: tb/tb_mul_lopd_norm_seq.sv
// tb/tb_mul_lopd_norm_seq.sv - scoreboard bench for mul_lopd_norm_seq (DATA_W=48)
// Exponent checks compile in when MUL_LOPD_NORM_EXP_ADJ_EN is defined.
module tb_mul_lopd_norm_seq;
  localparam int DATA_W = 48;
  localparam int NCHUNK = DATA_W / 16;

  typedef struct {
    logic [DATA_W-1:0] mant;
    int                lzc;
    logic              zero;
    int                lat;
    int                acc_cyc;
    logic [7:0]        exp;
    logic              uflow;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;
  bit   seen = 1'b0;
  exp_t sb[$];

  mul_lopd_norm_seq_if #(.DATA_W(DATA_W)) ifc ();

  mul_lopd_norm_seq #(.DATA_W(DATA_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [DATA_W-1:0] m, input logic [7:0] e);
    exp_t r;
    r.mant = m;
    r.lzc  = DATA_W;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      if (m[b]) begin
        r.lzc = DATA_W - 1 - b;
        break;
      end
    end
    r.zero    = (m == '0);
    r.mant    = r.zero ? '0 : (m << r.lzc);
    r.lat     = r.zero ? NCHUNK : (r.lzc / 16 + 1);
    r.acc_cyc = 0;
    if (r.zero) begin
      r.exp = 8'd0; r.uflow = 1'b0;
    end else if (int'(e) >= r.lzc) begin
      r.exp = 8'(int'(e) - r.lzc); r.uflow = 1'b0;
    end else begin
      r.exp = 8'd0; r.uflow = 1'b1;
    end
    return r;
  endfunction

  task automatic send(input logic [DATA_W-1:0] m, input logic [7:0] e, input bit push);
    int   n = 0;
    exp_t r;
    ifc.i_mant  = m;
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
    ifc.i_exp   = e;
`endif
    ifc.i_valid = 1'b1;
    while (!ifc.o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ifc.o_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    ifc.i_valid = 1'b0;
    if (push) begin
      r = model(m, e);
      r.acc_cyc = cyc;
      sb.push_back(r);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [DATA_W-1:0] gen_mant();
    logic [DATA_W-1:0] m;
    logic [15:0]       c;
    for (int k = 0; k < NCHUNK; k++) begin
      c = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) c = 16'd0;
      m = {m[DATA_W-17:0], c};
    end
    return m;
  endfunction

  // Downstream ready: always, random backpressure, or held low.
  initial begin
    ifc.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       ifc.i_ready = 1'b1;
        1:       ifc.i_ready = ($urandom_range(0, 3) != 0);
        default: ifc.i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every cycle a result is shown it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ifc.o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        chk("mant", 64'(ifc.o_mant), 64'(sb[0].mant));
        chk("lzc", 64'(ifc.o_lzc), 64'(sb[0].lzc));
        chk("zero", 64'(ifc.o_zero), 64'(sb[0].zero));
        chk("ready_in_done", 64'(ifc.o_ready), 64'd0);
        chk("busy_in_done", 64'(ifc.o_busy), 64'd1);
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
        chk("exp", 64'(ifc.o_exp), 64'(sb[0].exp));
        chk("uflow", 64'(ifc.o_uflow), 64'(sb[0].uflow));
`endif
        if (!seen) begin
          chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (ifc.i_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(ifc.o_valid), 64'd0);
    chk({tag, "_mant"}, 64'(ifc.o_mant), 64'd0);
    chk({tag, "_lzc"}, 64'(ifc.o_lzc), 64'd0);
    chk({tag, "_zero"}, 64'(ifc.o_zero), 64'd0);
    chk({tag, "_busy"}, 64'(ifc.o_busy), 64'd0);
    chk({tag, "_ready"}, 64'(ifc.o_ready), 64'd1);
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
    chk({tag, "_exp"}, 64'(ifc.o_exp), 64'd0);
    chk({tag, "_uflow"}, 64'(ifc.o_uflow), 64'd0);
`endif
  endtask

  initial begin
    int n;
    ifc.i_valid = 1'b0;
    ifc.i_mant  = '0;
`ifdef MUL_LOPD_NORM_EXP_ADJ_EN
    ifc.i_exp   = '0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(48'h8000_0000_0000, 8'd20, 1'b1);
    send(48'h0000_0001_0000, 8'd40, 1'b1);
    send(48'h0000_0000_0000, 8'd7, 1'b1);
    send(48'h0000_0001_0000, 8'd10, 1'b1);
    send(48'h0000_0000_0001, 8'd47, 1'b1);
    send(48'h0000_8000_0000, 8'd16, 1'b1);
    drain();

    // Held backpressure: result must stay put and a new request must be ignored.
    ready_mode = 2;
    send(48'h0000_0000_00F0, 8'd5, 1'b1);
    n = 0;
    while (!ifc.o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_valid_seen", 64'(ifc.o_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      ifc.i_valid = 1'b1;
      ifc.i_mant  = 48'hFFFF_FFFF_FFFF;
      @(posedge clk); #1;
      chk("stall_ready", 64'(ifc.o_ready), 64'd0);
      chk("stall_valid", 64'(ifc.o_valid), 64'd1);
    end
    ifc.i_valid = 1'b0;
    ready_mode  = 0;
    drain();
    send(48'h0123_4567_89AB, 8'd3, 1'b1);
    drain();

    // Reset while scanning an all-zero word: nothing may be reported afterwards.
    send(48'h0000_0000_0000, 8'd9, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_valid", 64'(ifc.o_valid), 64'd0);
    chk("post_reset_ready", 64'(ifc.o_ready), 64'd1);

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send(gen_mant(), 8'($urandom), 1'b1);
    end
    drain();
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
